// File: rtl/text_pkg.sv
// Shared text-mode definitions: screen geometry, control bytes, writer states
// and the row/column to character-RAM address mapping.
package text_pkg;

  localparam int unsigned COLS    = 80;
  localparam int unsigned ROWS    = 30;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned BLINK_W = 24;
  localparam int unsigned COL_W   = 7;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned SUM_W   = ROW_W + 1;

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [5:0] CODE_SPACE = 6'h20;

  typedef enum logic [1:0] {
    CLR_SCREEN = 2'd0,
    IDLE       = 2'd1,
    CLR_ROW    = 2'd2
  } writer_state_e;

  // Constant multiply; synthesis reduces it to (r<<6)+(r<<4) for 80 columns.
  function automatic logic [ADDR_W-1:0] row_addr(input logic [ROW_W-1:0] r);
    return ADDR_W'(r) * ADDR_W'(COLS);
  endfunction

  // Logical row plus scroll offset, wrapped without a divider.
  function automatic logic [ROW_W-1:0] phys_row_of(input logic [ROW_W-1:0] row,
                                                   input logic [ROW_W-1:0] top);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(row) + SUM_W'(top);
    if (sum >= SUM_W'(ROWS)) sum = sum - SUM_W'(ROWS);
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col,
                                                  input logic [ROW_W-1:0] top);
    return row_addr(phys_row_of(row, top)) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/text_buffer_writer.sv
// Byte-stream to character-RAM writer with cursor, wrap, backspace, clear and
// hardware scrolling. Optional cursor outputs under TEXT_WRITER_CURSOR_EN.
module text_buffer_writer
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [5:0]        ram_wdata,
  output logic [ROW_W-1:0]  top_row
`ifdef TEXT_WRITER_CURSOR_EN
  ,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              cursor_blink
`endif
);

  writer_state_e     state_q, state_n;
  logic [COL_W-1:0]  col_q, col_n;
  logic [ROW_W-1:0]  row_q, row_n, top_n;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_n, clr_last_q, clr_last_n;
  logic              ram_we_n, wr_ready_n;
  logic [ADDR_W-1:0] ram_addr_n;
  logic [5:0]        ram_wdata_n;
  logic              accept_c, is_print_c, do_lf;
  logic [5:0]        code_c;

  assign accept_c   = wr_valid && wr_ready;
  assign is_print_c = (wr_data >= 8'h20) && (wr_data <= 8'h7E);
  // Bit 5 survives only below 0x40; lowercase folds onto the uppercase code.
  assign code_c     = {wr_data[5] & ~wr_data[6], wr_data[4:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLR_SCREEN;
      col_q      <= '0;
      row_q      <= '0;
      top_row    <= '0;
      clr_addr_q <= '0;
      clr_last_q <= LAST_ADDR;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      wr_ready   <= 1'b0;
    end else begin
      state_q    <= state_n;
      col_q      <= col_n;
      row_q      <= row_n;
      top_row    <= top_n;
      clr_addr_q <= clr_addr_n;
      clr_last_q <= clr_last_n;
      ram_we     <= ram_we_n;
      ram_addr   <= ram_addr_n;
      ram_wdata  <= ram_wdata_n;
      wr_ready   <= wr_ready_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    col_n       = col_q;
    row_n       = row_q;
    top_n       = top_row;
    clr_addr_n  = clr_addr_q;
    clr_last_n  = clr_last_q;
    ram_we_n    = 1'b0;
    ram_addr_n  = ram_addr;
    ram_wdata_n = ram_wdata;
    wr_ready_n  = 1'b0;
    do_lf       = 1'b0;

    case (state_q)
      CLR_SCREEN, CLR_ROW: begin
        ram_we_n    = 1'b1;
        ram_addr_n  = clr_addr_q;
        ram_wdata_n = CODE_SPACE;
        clr_addr_n  = clr_addr_q + 1'b1;
        if (clr_addr_q == clr_last_q) state_n = IDLE;
      end

      IDLE: begin
        wr_ready_n = 1'b1;
        if (accept_c) begin
          if (is_print_c) begin
            ram_we_n    = 1'b1;
            ram_addr_n  = cell_addr(row_q, col_q, top_row);
            ram_wdata_n = code_c;
            if (col_q == LAST_COL) do_lf = 1'b1;
            else                   col_n = col_q + 1'b1;
          end else begin
            case (wr_data)
              CH_LF: do_lf = 1'b1;
              CH_CR: col_n = '0;
              CH_BS: begin
                if (col_q != '0) begin
                  col_n       = col_q - 1'b1;
                  ram_we_n    = 1'b1;
                  ram_addr_n  = cell_addr(row_q, col_q - 1'b1, top_row);
                  ram_wdata_n = CODE_SPACE;
                end else if (row_q != '0) begin
                  row_n       = row_q - 1'b1;
                  col_n       = LAST_COL;
                  ram_we_n    = 1'b1;
                  ram_addr_n  = cell_addr(row_q - 1'b1, LAST_COL, top_row);
                  ram_wdata_n = CODE_SPACE;
                end
              end
              CH_FF: begin
                col_n      = '0;
                row_n      = '0;
                top_n      = '0;
                state_n    = CLR_SCREEN;
                clr_addr_n = '0;
                clr_last_n = LAST_ADDR;
                wr_ready_n = 1'b0;
              end
              default: ;
            endcase
          end

          // Line feed; at the bottom row scroll and blank the recycled row.
          if (do_lf) begin
            col_n      = '0;
            wr_ready_n = 1'b0;
            if (row_q != LAST_ROW) begin
              row_n = row_q + 1'b1;
            end else begin
              top_n      = (top_row == LAST_ROW) ? '0 : top_row + 1'b1;
              state_n    = CLR_ROW;
              clr_addr_n = row_addr(top_row);
              clr_last_n = row_addr(top_row) + ADDR_W'(COLS - 1);
            end
          end
        end
      end

      default: state_n = CLR_SCREEN;
    endcase
  end

`ifdef TEXT_WRITER_CURSOR_EN
  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt    <= '0;
      cursor_blink <= 1'b0;
      cursor_addr  <= '0;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
      if (&blink_cnt) cursor_blink <= ~cursor_blink;
      cursor_addr <= cell_addr(row_n, col_n, top_n);
    end
  end
`endif

endmodule

// File: tb/tb_text_buffer_writer.sv
// Self-checking bench for text_buffer_writer: vector table, directed corner
// sequences and a random byte stream against a logical-screen model.
module tb_text_buffer_writer;
  import text_pkg::*;

  localparam int unsigned NCELL = ROWS * COLS;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic              wr_ready;
  logic [7:0]        wr_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [5:0]        ram_wdata;
  logic [ROW_W-1:0]  top_row;
`ifdef TEXT_WRITER_CURSOR_EN
  logic [ADDR_W-1:0] cursor_addr;
  logic              cursor_blink;
`endif

  text_buffer_writer dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .top_row   (top_row)
`ifdef TEXT_WRITER_CURSOR_EN
    ,
    .cursor_addr  (cursor_addr),
    .cursor_blink (cursor_blink)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Character RAM as the picture generator would see it.
  logic [5:0] dut_ram [NCELL];
  always @(posedge clk)
    if (ram_we === 1'b1 && ram_addr < ADDR_W'(NCELL)) dut_ram[ram_addr] <= ram_wdata;

  // Reference: logical screen rows (row 0 = top of display) plus scroll count.
  logic [5:0] scr [ROWS][COLS];
  int m_row, m_col, m_top;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++) scr[r][c] = 6'h20;
    m_row = 0; m_col = 0; m_top = 0;
  endtask

  task automatic model_newline();
    m_col = 0;
    if (m_row < int'(ROWS) - 1) m_row++;
    else begin
      for (int r = 0; r < int'(ROWS) - 1; r++)
        for (int c = 0; c < int'(COLS); c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < int'(COLS); c++) scr[ROWS-1][c] = 6'h20;
      m_top = (m_top + 1) % int'(ROWS);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] u;
    if (b >= 8'h20 && b <= 8'h7E) begin
      u = (b >= 8'h60) ? b - 8'h20 : b;
      scr[m_row][m_col] = u[5:0];
      m_col++;
      if (m_col == int'(COLS)) model_newline();
    end else if (b == 8'h0A) model_newline();
    else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h0C) model_clear();
    else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--; scr[m_row][m_col] = 6'h20;
      end else if (m_row > 0) begin
        m_row--; m_col = int'(COLS) - 1; scr[m_row][m_col] = 6'h20;
      end
    end
  endtask

  // Hand one byte over; returns #1 after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    while (wr_ready !== 1'b1 && waited < 5000) begin @(negedge clk); waited++; end
    if (wr_ready !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL ready_timeout: wr_ready stuck at %b for byte 0x%0h", wr_ready, b);
    end
    wr_valid = 1'b1; wr_data = b;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  // Expect n consecutive space writes from 'first', then ready one cycle later.
  task automatic expect_clear(input string name, input int first, input int n);
    int cnt = 0, bad = 0, cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      if (ram_we === 1'b1) begin
        if (ram_addr !== ADDR_W'(first + cnt) || ram_wdata !== 6'h20 || wr_ready !== 1'b0) bad++;
        cnt++;
      end
      if (wr_ready === 1'b1) break;
    end
    check({name, "_count"}, cnt, n);
    check({name, "_seq"}, bad, 0);
    check({name, "_ready"}, wr_ready, 1);
  endtask

  task automatic drive_random(input int nbytes);
    logic [7:0] b;
    int sel, waited;
    @(negedge clk);
    for (int i = 0; i < nbytes; i++) begin
      sel = $urandom_range(0, 199);
      if      (sel < 140) b = 8'($urandom_range(8'h20, 8'h7E));
      else if (sel < 165) b = CH_LF;
      else if (sel < 175) b = CH_CR;
      else if (sel < 190) b = CH_BS;
      else if (sel < 191) b = CH_FF;
      else                b = 8'($urandom_range(8'h80, 8'hFF));
      if ($urandom_range(0, 3) == 0) begin wr_valid = 1'b0; @(negedge clk); end
      wr_valid = 1'b1; wr_data = b; waited = 0;
      while (wr_ready !== 1'b1 && waited < 5000) begin @(negedge clk); waited++; end
      if (wr_ready !== 1'b1) begin
        n_checks++; n_errors++;
        $display("FAIL rand_ready_timeout: wr_ready %b at byte %0d", wr_ready, i);
        break;
      end
      @(posedge clk);
      model_byte(b);
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  task automatic compare_screen(input string name);
    int waited = 0, mism = 0, idx;
    @(negedge clk);
    while (wr_ready !== 1'b1 && waited < 5000) begin @(negedge clk); waited++; end
    @(posedge clk); @(negedge clk);
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++) begin
        idx = ((m_top + r) % int'(ROWS)) * int'(COLS) + c;
        if (dut_ram[idx] !== scr[r][c]) mism++;
      end
    check({name, "_cells"}, mism, 0);
    check({name, "_top_row"}, top_row, m_top);
  endtask

  typedef struct {
    logic [7:0]        data;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [5:0]        wdata;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h31, 1'b1, 12'd0,  6'h31};
    vecs[1]  = '{8'h37, 1'b1, 12'd1,  6'h37};
    vecs[2]  = '{8'h61, 1'b1, 12'd2,  6'h01};
    vecs[3]  = '{8'h07, 1'b0, 12'd0,  6'h00};
    vecs[4]  = '{8'h0D, 1'b0, 12'd0,  6'h00};
    vecs[5]  = '{8'h08, 1'b0, 12'd0,  6'h00};
    vecs[6]  = '{8'h41, 1'b1, 12'd0,  6'h01};
    vecs[7]  = '{8'h08, 1'b1, 12'd0,  6'h20};
    vecs[8]  = '{8'h0A, 1'b0, 12'd0,  6'h00};
    vecs[9]  = '{8'h5A, 1'b1, 12'd80, 6'h1A};
    vecs[10] = '{8'h08, 1'b1, 12'd80, 6'h20};
    vecs[11] = '{8'h08, 1'b1, 12'd79, 6'h20};
    vecs[12] = '{8'h7E, 1'b1, 12'd79, 6'h1E};
    vecs[13] = '{8'h20, 1'b1, 12'd80, 6'h20};

    reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_top_row", top_row, 0);
    @(negedge clk); reset = 1'b0;
    expect_clear("power_on_clear", 0, 2400);
    check("power_on_top_row", top_row, 0);

    for (int i = 0; i < NV; i++) begin
      send_byte(vecs[i].data);
      check($sformatf("vec%0d_we", i), ram_we, vecs[i].we);
      if (vecs[i].we) begin
        check($sformatf("vec%0d_addr", i), ram_addr, vecs[i].addr);
        check($sformatf("vec%0d_wdata", i), ram_wdata, vecs[i].wdata);
      end
    end

    // 80 characters fill row 0 exactly and wrap to row 1 without scrolling.
    send_byte(CH_FF);
    expect_clear("ff_clear", 0, 2400);
    for (int i = 0; i < int'(COLS); i++) send_byte(8'h41);
    check("row_fill_last_addr", ram_addr, 79);
    check("row_fill_top_row", top_row, 0);
    send_byte(8'h42);
    check("row_fill_next_addr", ram_addr, 80);

    // LF on the bottom row scrolls and blanks physical row 0.
    send_byte(CH_FF);
    expect_clear("ff_clear2", 0, 2400);
    for (int i = 0; i < int'(ROWS) - 1; i++) send_byte(CH_LF);
    for (int i = 0; i < 5; i++) send_byte(8'h42);
    send_byte(CH_LF);
    check("scroll_lf_no_write", ram_we, 0);
    check("scroll_lf_ready_low", wr_ready, 0);
    check("scroll_top_row", top_row, 1);
    expect_clear("scroll_clear", 0, 80);
    send_byte(8'h41);
    check("after_scroll_addr", ram_addr, 0);
    check("after_scroll_wdata", ram_wdata, 6'h01);

    // Wrap at the last cell of the bottom row: char write, then row clear.
    for (int i = 0; i < 78; i++) send_byte(8'h43);
    send_byte(8'h44);
    check("wrap_we", ram_we, 1);
    check("wrap_addr", ram_addr, 79);
    check("wrap_wdata", ram_wdata, 6'h04);
    expect_clear("wrap_clear", 80, 80);
    check("wrap_top_row", top_row, 2);
    send_byte(8'h45);
    check("after_wrap_addr", ram_addr, 80);

    // Backspace from column 0 of row 3 erases row 2 column 79.
    send_byte(CH_FF);
    expect_clear("ff_clear3", 0, 2400);
    for (int i = 0; i < 3; i++) send_byte(CH_LF);
    send_byte(CH_BS);
    check("bs_row_we", ram_we, 1);
    check("bs_row_addr", ram_addr, 239);
    check("bs_row_wdata", ram_wdata, 6'h20);

    // Reset in the middle of a row clear restarts the full screen clear.
    send_byte(CH_FF);
    expect_clear("ff_clear4", 0, 2400);
    for (int i = 0; i < int'(ROWS); i++) send_byte(CH_LF);
    repeat (10) @(posedge clk);
    #1;
    check("midclr_busy", ram_we, 1);
    check("midclr_top_row", top_row, 1);
    reset = 1'b1;
    #1;
    check("midclr_rst_we", ram_we, 0);
    check("midclr_rst_ready", wr_ready, 0);
    check("midclr_rst_top_row", top_row, 0);
    check("midclr_rst_addr", ram_addr, 0);
    @(negedge clk); reset = 1'b0;
    expect_clear("restart_clear", 0, 2400);

    // Random stream against the logical-screen model.
    send_byte(CH_FF);
    expect_clear("rand_start_clear", 0, 2400);
    model_clear();
    compare_screen("rand_init");
    for (int k = 0; k < 12; k++) begin
      drive_random(100);
      compare_screen($sformatf("rand_chunk%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
